// File: rtl/sr_arb_pkg.sv
// ---------------------------------------------------------------------------
// sr_arb_pkg
// Shared definitions for the SR flag arbiter slice.
//   CMD_SET / CMD_CLR : encoding of a requester's cmd_set bit.
//   clog2             : ceiling log2, used to size the pointer and to check
//                       that the flag index field can address every flag.
//   params_ok         : legal-range check for the arbiter parameters.
// ---------------------------------------------------------------------------
package sr_arb_pkg;

    localparam logic CMD_SET = 1'b1;
    localparam logic CMD_CLR = 1'b0;

    localparam int N_REQ_MIN  = 2;
    localparam int N_REQ_MAX  = 8;
    localparam int N_FLAG_MIN = 1;
    localparam int N_FLAG_MAX = 16;

    // Ceiling log2; clog2(1) = 0, clog2(5) = 3.
    function automatic int clog2(input int value);
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) >= value) begin
                return i;
            end
        end
        return 31;
    endfunction

    // True when the requester count, flag count and index width are usable.
    function automatic bit params_ok(input int n_req, input int n_flag, input int idxw);
        return (n_req >= N_REQ_MIN) && (n_req <= N_REQ_MAX) &&
               (n_flag >= N_FLAG_MIN) && (n_flag <= N_FLAG_MAX) &&
               (idxw >= 1) && (idxw >= clog2(n_flag)) && (idxw <= 8);
    endfunction

endpackage

// File: rtl/sr_flag_cell.sv
// ---------------------------------------------------------------------------
// sr_flag_cell
// One clocked SR status flag.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears q
//   s     : set pulse   (q <= 1 on the next edge)
//   r     : reset pulse (q <= 0 on the next edge)
//   q     : flag state
//   q_bar : complement of q
// s and r together hold the current state; the arbiter never drives that
// combination, the hold is only a safe fallback.
// ---------------------------------------------------------------------------
module sr_flag_cell (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q,
    output logic q_bar
);

    logic q_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= 1'b0;
        end else if (s && !r) begin
            q_reg <= 1'b1;
        end else if (r && !s) begin
            q_reg <= 1'b0;
        end
    end

    assign q     = q_reg;
    assign q_bar = ~q_reg;

endmodule

// File: rtl/sr_flag_arbiter.sv
// ---------------------------------------------------------------------------
// sr_flag_arbiter
// Round-robin arbiter sharing a bank of SR flag cells among N_REQ
// requesters. One request is granted per cycle; the grant is turned into a
// registered single-cycle S or R pulse on the addressed cell.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   req     : per-requester request, held until acked
//   cmd_set : per-requester command, 1 = set flag, 0 = clear flag
//   idx     : per-requester flag index, requester i uses [i*IDXW +: IDXW]
//   ack     : combinational one-hot grant (zero while rst is high)
//   flag_s  : registered set pulses to the cell bank
//   flag_r  : registered reset pulses to the cell bank
//   q       : flag states
//   q_bar   : complemented flag states
//   err     : registered one-cycle pulse for a grant with idx >= N_FLAG
// ---------------------------------------------------------------------------
module sr_flag_arbiter
    import sr_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int N_FLAG = 8,
    parameter int IDXW   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      cmd_set,
    input  logic [N_REQ*IDXW-1:0] idx,
    output logic [N_REQ-1:0]      ack,
    output logic [N_FLAG-1:0]     flag_s,
    output logic [N_FLAG-1:0]     flag_r,
    output logic [N_FLAG-1:0]     q,
    output logic [N_FLAG-1:0]     q_bar,
    output logic                  err
);

    localparam int PTRW = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ);

    // Elaboration-time guard on the parameter set.
    if (!params_ok(N_REQ, N_FLAG, IDXW)) begin : g_param_check
        $error("sr_flag_arbiter: illegal parameters N_REQ=%0d N_FLAG=%0d IDXW=%0d",
               N_REQ, N_FLAG, IDXW);
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [PTRW-1:0]   ptr_reg;
    logic [PTRW-1:0]   ptr_next;
    logic [N_FLAG-1:0] flag_s_reg;
    logic [N_FLAG-1:0] flag_r_reg;
    logic              err_reg;

    logic [N_FLAG-1:0] flag_s_next;
    logic [N_FLAG-1:0] flag_r_next;
    logic              err_next;

    // -----------------------------------------------------------------------
    // Per-requester views
    // -----------------------------------------------------------------------
    logic [IDXW-1:0] req_idx [N_REQ];
    // cand[k] is the requester examined k-th when searching from ptr_reg.
    logic [PTRW-1:0] cand    [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign req_idx[gi] = idx[gi*IDXW +: IDXW];
        assign cand[gi]    = PTRW'((int'(ptr_reg) + gi) % N_REQ);
    end

    // -----------------------------------------------------------------------
    // Round-robin search: first requesting candidate starting at ptr_reg.
    // -----------------------------------------------------------------------
    logic            grant_any;
    logic [PTRW-1:0] win;

    always_comb begin
        grant_any = 1'b0;
        win       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_any && req[cand[k]]) begin
                grant_any = 1'b1;
                win       = cand[k];
            end
        end
    end

    // Reset is asynchronous, so the grant is gated by it combinationally:
    // nothing may be acked while the registers are being held clear.
    logic grant_valid;
    assign grant_valid = grant_any && !rst;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
        assign ack[gi] = grant_valid && (win == PTRW'(gi));
    end

    // -----------------------------------------------------------------------
    // Winner's command decode
    // -----------------------------------------------------------------------
    logic            win_cmd;
    logic [IDXW-1:0] win_idx;
    logic            in_range;

    assign win_cmd  = cmd_set[win];
    assign win_idx  = req_idx[win];
    assign in_range = int'(win_idx) < N_FLAG;

    // Only one flag can match win_idx and win_cmd selects exactly one of
    // S or R, so S and R can never be set together nor on two cells.
    for (genvar gi = 0; gi < N_FLAG; gi++) begin : g_decode
        logic hit;
        assign hit             = grant_valid && in_range && (int'(win_idx) == gi);
        assign flag_s_next[gi] = hit && (win_cmd == CMD_SET);
        assign flag_r_next[gi] = hit && (win_cmd == CMD_CLR);
    end

    assign err_next = grant_valid && !in_range;
    assign ptr_next = (int'(win) == N_REQ - 1) ? '0 : win + PTRW'(1);

    // -----------------------------------------------------------------------
    // Pulse and pointer registers. Pulses last exactly one cycle because
    // they are reloaded from the decode every cycle (zero when idle).
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg    <= '0;
            flag_s_reg <= '0;
            flag_r_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            flag_s_reg <= flag_s_next;
            flag_r_reg <= flag_r_next;
            err_reg    <= err_next;
            if (grant_valid) begin
                ptr_reg <= ptr_next;
            end
        end
    end

    assign flag_s = flag_s_reg;
    assign flag_r = flag_r_reg;
    assign err    = err_reg;

    // -----------------------------------------------------------------------
    // Flag cell bank
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < N_FLAG; gi++) begin : g_cell
        sr_flag_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .s     (flag_s_reg[gi]),
            .r     (flag_r_reg[gi]),
            .q     (q[gi]),
            .q_bar (q_bar[gi])
        );
    end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sr_flag_arbiter
// Directed bench for sr_flag_arbiter. The main instance uses the default
// 4 requesters / 8 flags; a second instance with 6 flags exercises the
// out-of-range index path. Inputs change on the falling edge, outputs are
// compared on the falling edge (registered) or 1 ns after an input change
// (combinational ack).
// ---------------------------------------------------------------------------
module tb_sr_flag_arbiter;

    logic        clk;
    logic        rst;

    // Main instance: N_FLAG = 8
    logic [3:0]  req;
    logic [3:0]  cmd_set;
    logic [11:0] idx;
    logic [3:0]  ack;
    logic [7:0]  flag_s;
    logic [7:0]  flag_r;
    logic [7:0]  q;
    logic [7:0]  q_bar;
    logic        err;

    // Second instance: N_FLAG = 6
    logic [3:0]  req6;
    logic [3:0]  cmd_set6;
    logic [11:0] idx6;
    logic [3:0]  ack6;
    logic [5:0]  flag_s6;
    logic [5:0]  flag_r6;
    logic [5:0]  q6;
    logic [5:0]  q_bar6;
    logic        err6;

    int total;
    int bad;

    sr_flag_arbiter #(.N_REQ(4), .N_FLAG(8), .IDXW(3)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .cmd_set (cmd_set),
        .idx     (idx),
        .ack     (ack),
        .flag_s  (flag_s),
        .flag_r  (flag_r),
        .q       (q),
        .q_bar   (q_bar),
        .err     (err)
    );

    sr_flag_arbiter #(.N_REQ(4), .N_FLAG(6), .IDXW(3)) u_dut6 (
        .clk     (clk),
        .rst     (rst),
        .req     (req6),
        .cmd_set (cmd_set6),
        .idx     (idx6),
        .ack     (ack6),
        .flag_s  (flag_s6),
        .flag_r  (flag_r6),
        .q       (q6),
        .q_bar   (q_bar6),
        .err     (err6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s got=%0h @%0t", tag, got, $time);
        end
    endtask

    task automatic drive(input int r, input logic c, input int ix);
        req[r]           = 1'b1;
        cmd_set[r]       = c;
        idx[r*3 +: 3]    = ix[2:0];
    endtask

    task automatic drive6(input int r, input logic c, input int ix);
        req6[r]          = 1'b1;
        cmd_set6[r]      = c;
        idx6[r*3 +: 3]   = ix[2:0];
    endtask

    // Invariants checked every cycle on both instances.
    always @(negedge clk) begin
        check("sr_excl",    32'(flag_s & flag_r), 32'h0);
        check("ack_1hot",   32'($countones(ack) <= 1), 32'h1);
        check("sr_excl6",   32'(flag_s6 & flag_r6), 32'h0);
        check("ack_1hot6",  32'($countones(ack6) <= 1), 32'h1);
    end

    // Round-robin contention expectations, one entry per grant.
    logic [3:0] rr_ack [5];
    logic [7:0] rr_s   [5];
    logic [7:0] rr_r   [5];

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        req      = 4'b1111;
        cmd_set  = '0;
        idx      = '0;
        req6     = '0;
        cmd_set6 = '0;
        idx6     = '0;

        rr_ack[0] = 4'b0001; rr_s[0] = 8'h01; rr_r[0] = 8'h00;
        rr_ack[1] = 4'b0010; rr_s[1] = 8'h02; rr_r[1] = 8'h00;
        rr_ack[2] = 4'b0100; rr_s[2] = 8'h00; rr_r[2] = 8'h20;
        rr_ack[3] = 4'b1000; rr_s[3] = 8'h80; rr_r[3] = 8'h00;
        rr_ack[4] = 4'b0001; rr_s[4] = 8'h01; rr_r[4] = 8'h00;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_ack",    32'(ack),    32'h0);
        check("rst_q",      32'(q),      32'h00);
        check("rst_qbar",   32'(q_bar),  32'hFF);
        check("rst_s",      32'(flag_s), 32'h00);
        check("rst_r",      32'(flag_r), 32'h00);
        check("rst_err",    32'(err),    32'h0);
        check("rst_qbar6",  32'(q_bar6), 32'h3F);
        rst = 1'b0;
        req = '0;
        @(negedge clk);

        // ---------------- single set: r2 sets flag 5 ----------------
        drive(2, 1'b1, 5);
        #1 check("set_ack", 32'(ack), 32'b0100);
        @(negedge clk);
        check("set_s",      32'(flag_s), 32'h20);
        check("set_r",      32'(flag_r), 32'h00);
        check("set_q_pre",  32'(q),      32'h00);
        req = '0;
        @(negedge clk);
        check("set_q",      32'(q),      32'h20);
        check("set_qbar",   32'(q_bar),  32'hDF);
        check("set_s_end",  32'(flag_s), 32'h00);

        // ---------------- legal clear of a clear flag (ptr=3) ----------------
        drive(3, 1'b0, 0);
        #1 check("noop_ack", 32'(ack), 32'b1000);
        @(negedge clk);
        check("noop_r", 32'(flag_r), 32'h01);
        req = '0;
        @(negedge clk);
        check("noop_q", 32'(q), 32'h20);

        // ---------------- contention from ptr=0 ----------------
        drive(0, 1'b1, 0);
        drive(1, 1'b1, 1);
        drive(2, 1'b0, 5);
        drive(3, 1'b1, 7);
        for (int k = 0; k < 5; k++) begin
            #1 check($sformatf("rr_ack%0d", k), 32'(ack), 32'(rr_ack[k]));
            @(negedge clk);
            check($sformatf("rr_s%0d", k), 32'(flag_s), 32'(rr_s[k]));
            check($sformatf("rr_r%0d", k), 32'(flag_r), 32'(rr_r[k]));
            if (k == 4) req = '0;
        end
        @(negedge clk);
        check("rr_q", 32'(q), 32'h83);

        // ptr=1: lone r3 is found by wrap-around; re-set of a set flag
        drive(3, 1'b1, 7);
        #1 check("wrap_ack", 32'(ack), 32'b1000);
        @(negedge clk);
        check("wrap_s", 32'(flag_s), 32'h80);
        req = '0;

        // ---------------- same-flag conflict from ptr=0 ----------------
        drive(0, 1'b1, 3);
        drive(1, 1'b0, 3);
        #1 check("cf_ack0", 32'(ack), 32'b0001);
        @(negedge clk);
        check("cf_s", 32'(flag_s), 32'h08);
        check("cf_r0", 32'(flag_r), 32'h00);
        req[0] = 1'b0;
        #1 check("cf_ack1", 32'(ack), 32'b0010);
        @(negedge clk);
        check("cf_r", 32'(flag_r), 32'h08);
        check("cf_s1", 32'(flag_s), 32'h00);
        check("cf_q_mid", 32'(q), 32'h8B);
        req = '0;
        @(negedge clk);
        check("cf_q", 32'(q), 32'h83);

        // ---------------- out-of-range on the 6-flag instance ----------------
        drive6(1, 1'b1, 7);
        #1 check("oor_ack", 32'(ack6), 32'b0010);
        @(negedge clk);
        check("oor_err", 32'(err6), 32'h1);
        check("oor_s",   32'(flag_s6), 32'h00);
        check("oor_r",   32'(flag_r6), 32'h00);
        req6 = '0;
        drive6(2, 1'b1, 6);
        #1 check("edge_ack", 32'(ack6), 32'b0100);
        @(negedge clk);
        check("edge_err", 32'(err6), 32'h1);
        check("edge_s",   32'(flag_s6), 32'h00);
        req6 = '0;
        drive6(3, 1'b1, 5);
        #1 check("top_ack", 32'(ack6), 32'b1000);
        @(negedge clk);
        check("top_err", 32'(err6), 32'h0);
        check("top_s",   32'(flag_s6), 32'h20);
        req6 = '0;
        @(negedge clk);
        check("oor_q6",  32'(q6), 32'h20);
        check("oor_err_end", 32'(err6), 32'h0);

        // ---------------- reset mid-operation (main ptr=2) ----------------
        drive(2, 1'b1, 2);
        #1 check("mr_ack", 32'(ack), 32'b0100);
        @(negedge clk);
        check("mr_s", 32'(flag_s), 32'h04);
        rst = 1'b1;
        drive(3, 1'b1, 6);
        #1;
        check("mr_s_clr", 32'(flag_s), 32'h00);
        check("mr_q_clr", 32'(q), 32'h00);
        check("mr_ack_gate", 32'(ack), 32'h0);
        @(negedge clk);
        check("mr_q_hold", 32'(q), 32'h00);
        check("mr_s_hold", 32'(flag_s), 32'h00);
        rst = 1'b0;
        #1 check("mr_rearb", 32'(ack), 32'b0100);
        @(negedge clk);
        check("mr_s2", 32'(flag_s), 32'h04);
        req[2] = 1'b0;
        #1 check("mr_ack3", 32'(ack), 32'b1000);
        @(negedge clk);
        check("mr_s3", 32'(flag_s), 32'h40);
        check("mr_q2", 32'(q), 32'h04);
        req = '0;
        @(negedge clk);
        check("mr_q3", 32'(q), 32'h44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
